seq_chunk_adder: RTL and testbench

//  Multi-cycle, parametrised ripple adder: adds two WIDTH-bit operands CHUNK bits per clock,

---
 rtl/seq_chunk_adder_pkg.sv | 16 +
 rtl/seq_chunk_adder_chunk_adder.sv | 25 ++
 rtl/seq_chunk_adder.sv | 121 ++++++++++++
 tb/tb_seq_chunk_adder.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/seq_chunk_adder_pkg.sv
// Shared types for the chunked sequential adder: operand modes and FSM states.
package seq_chunk_adder_pkg;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    XNB = 2'b10
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/seq_chunk_adder_chunk_adder.sv
// N-bit ripple of full adders; also exposes the carry into the top bit for signed overflow.
module chunk_adder #(
  parameter int N = 2
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         c_i,
  output logic [N-1:0] s_o,
  output logic         co_o,
  output logic         c_msb_o
);

  logic [N:0] c;

  assign c[0] = c_i;

  for (genvar g = 0; g < N; g++) begin : g_fa
    assign s_o[g]   = a_i[g] ^ b_i[g] ^ c[g];
    assign c[g+1]   = (a_i[g] & b_i[g]) | (c[g] & (a_i[g] ^ b_i[g]));
  end

  assign co_o    = c[N];
  assign c_msb_o = c[N-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder: adds WIDTH-bit operands CHUNK bits per clock with a registered carry.
module seq_chunk_adder
  import seq_chunk_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] key_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = $clog2(NCHUNK) + 1;

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_chk
    $error("seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
  end

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q, sum_d;
  logic [IDXW-1:0]  idx_q;
  logic             carry_q, cout_q, ovf_q;

  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic [CHUNK-1:0] a_ch, b_ch, s_ch;
  logic             co_ch, cmsb_ch, last;

  // SUB is a + ~b + 1, so the operand conditioning happens once at latch time.
  always_comb begin
    b_eff = b_i;
    c0    = cin_i;
    if (mode_i == SUB) begin
      b_eff = ~b_i;
      c0    = 1'b1;
    end else if (mode_i == XNB) begin
      b_eff = b_i ~^ key_i;
    end
  end

  always_comb begin
    a_ch  = '0;
    b_ch  = '0;
    sum_d = sum_q;
    for (int g = 0; g < NCHUNK; g++) begin
      if (idx_q == IDXW'(g)) begin
        a_ch                    = a_q[g*CHUNK +: CHUNK];
        b_ch                    = b_q[g*CHUNK +: CHUNK];
        sum_d[g*CHUNK +: CHUNK] = s_ch;
      end
    end
  end

  chunk_adder #(.N(CHUNK)) u_chunk (
    .a_i     (a_ch),
    .b_i     (b_ch),
    .c_i     (carry_q),
    .s_o     (s_ch),
    .co_o    (co_ch),
    .c_msb_o (cmsb_ch)
  );

  assign last = (idx_q == IDXW'(NCHUNK - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            a_q     <= a_i;
            b_q     <= b_eff;
            carry_q <= c0;
            idx_q   <= '0;
            sum_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= co_ch;
          idx_q   <= idx_q + 1'b1;
          // Top chunk's carries are the full-width carries, so flags come from here.
          if (last) begin
            cout_q  <= co_ch;
            ovf_q   <= co_ch ^ cmsb_ch;
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sum_o  = sum_q;
  assign cout_o = cout_q;
  assign ovf_o  = ovf_q;
  assign busy_o = (state_q == RUN);
  assign done_o = (state_q == DONE);

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Randomized and directed checks of seq_chunk_adder (CHUNK=2 and CHUNK=8) against an arithmetic model.
module tb_seq_chunk_adder;

  logic       clk = 1'b0;
  logic       rst, start2, start8, cin;
  logic [1:0] mode;
  logic [7:0] a, b, key;

  logic [7:0] sum2, sum8;
  logic       cout2, cout8, ovf2, ovf8, busy2, busy8, done2, done8;

  logic       sel8;
  logic [7:0] r_sum;
  logic       r_cout, r_ovf, r_busy, r_done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_chunk_adder #(.WIDTH(8), .CHUNK(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start2), .mode_i(mode), .a_i(a), .b_i(b),
    .key_i(key), .cin_i(cin), .sum_o(sum2), .cout_o(cout2), .ovf_o(ovf2),
    .busy_o(busy2), .done_o(done2)
  );

  seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(start8), .mode_i(mode), .a_i(a), .b_i(b),
    .key_i(key), .cin_i(cin), .sum_o(sum8), .cout_o(cout8), .ovf_o(ovf8),
    .busy_o(busy8), .done_o(done8)
  );

  assign r_sum  = sel8 ? sum8  : sum2;
  assign r_cout = sel8 ? cout8 : cout2;
  assign r_ovf  = sel8 ? ovf8  : ovf2;
  assign r_busy = sel8 ? busy8 : busy2;
  assign r_done = sel8 ? done8 : done2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // {cout, ovf, sum} from plain integer arithmetic on the conditioned operands.
  function automatic logic [9:0] model(input logic [1:0] md, input logic [7:0] av,
                                       input logic [7:0] bv, input logic [7:0] kv,
                                       input logic cv);
    logic [7:0] be;
    logic       c, ov;
    logic [8:0] full;
    be = bv;
    c  = cv;
    if (md == 2'b01) begin
      be = ~bv;
      c  = 1'b1;
    end else if (md == 2'b10) begin
      be = ~(bv ^ kv);
    end
    full = {1'b0, av} + {1'b0, be} + {8'd0, c};
    ov   = (av[7] == be[7]) && (full[7] != av[7]);
    return {full[8], ov, full[7:0]};
  endfunction

  task automatic wait_done(output int lat);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (r_done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input bit w8, input logic [1:0] md,
                        input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] kv, input logic cv);
    logic [9:0] e;
    int lat;
    e = model(md, av, bv, kv, cv);
    sel8 = w8;
    @(negedge clk);
    mode = md; a = av; b = bv; key = kv; cin = cv;
    if (w8) start8 = 1'b1; else start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0; start8 = 1'b0;
    // Scramble live inputs: only the latched copies may matter.
    a = 8'($urandom); b = 8'($urandom); key = 8'($urandom);
    mode = 2'($urandom); cin = 1'($urandom);
    chk({tag, ".busy"}, 32'(r_busy), 32'd1);
    wait_done(lat);
    chk({tag, ".lat"}, 32'(lat), w8 ? 32'd1 : 32'd4);
    chk({tag, ".sum"}, 32'(r_sum), 32'(e[7:0]));
    chk({tag, ".cout"}, 32'(r_cout), 32'(e[9]));
    chk({tag, ".ovf"}, 32'(r_ovf), 32'(e[8]));
    @(posedge clk); #1;
    chk({tag, ".done_drop"}, 32'(r_done), 32'd0);
    chk({tag, ".held"}, 32'(r_sum), 32'(e[7:0]));
  endtask

  initial begin
    int lat, ndone;
    rst = 1'b1; start2 = 1'b0; start8 = 1'b0; sel8 = 1'b0;
    mode = 2'b00; a = '0; b = '0; key = '0; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst.sum", 32'(sum2), 32'd0);
    chk("rst.cout", 32'(cout2), 32'd0);
    chk("rst.ovf", 32'(ovf2), 32'd0);
    chk("rst.busy", 32'(busy2), 32'd0);
    chk("rst.done", 32'(done2), 32'd0);

    run_op("add3c55", 1'b0, 2'b00, 8'h3C, 8'h55, 8'h00, 1'b0);
    chk("add3c55.const", 32'(sum2), 32'h91);
    run_op("addff01", 1'b0, 2'b00, 8'hFF, 8'h01, 8'h00, 1'b0);
    run_op("addff01c", 1'b0, 2'b00, 8'hFF, 8'h01, 8'h00, 1'b1);
    chk("addff01c.const", 32'(sum2), 32'h01);
    run_op("sub1020", 1'b0, 2'b01, 8'h10, 8'h20, 8'h00, 1'b1);
    chk("sub1020.const", 32'(sum2), 32'hF0);
    run_op("sub8001", 1'b0, 2'b01, 8'h80, 8'h01, 8'h00, 1'b0);
    chk("sub8001.ovf", 32'(ovf2), 32'd1);
    run_op("xnb", 1'b0, 2'b10, 8'h01, 8'h0F, 8'hF0, 1'b0);
    run_op("mode3", 1'b0, 2'b11, 8'h7F, 8'h01, 8'hAA, 1'b0);

    // start pulsed mid-RUN must be ignored
    sel8 = 1'b0;
    @(negedge clk);
    mode = 2'b00; a = 8'h11; b = 8'h22; cin = 1'b0; start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    @(posedge clk); #1 start2 = 1'b1; a = 8'hFF; b = 8'hFF; mode = 2'b01;
    @(posedge clk); #1 start2 = 1'b0;
    wait_done(lat);
    chk("ign.lat", 32'(lat + 2), 32'd4);
    chk("ign.sum", 32'(sum2), 32'h33);
    @(posedge clk); #1;
    chk("ign.idle", 32'(busy2), 32'd0);

    // reset in the second RUN cycle aborts with no done
    @(negedge clk);
    a = 8'h44; b = 8'h44; mode = 2'b00; start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("abort.busy", 32'(busy2), 32'd0);
    chk("abort.sum", 32'(sum2), 32'd0);
    chk("abort.cout", 32'(cout2), 32'd0);
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      if (done2) ndone++;
      @(posedge clk); #1;
    end
    chk("abort.nodone", 32'(ndone), 32'd0);

    // rst and start together: rst wins
    @(negedge clk);
    rst = 1'b1; start2 = 1'b1;
    @(posedge clk); #1 rst = 1'b0; start2 = 1'b0;
    chk("rststart.busy", 32'(busy2), 32'd0);

    for (int i = 0; i < 150; i++)
      run_op("rnd2", 1'b0, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
             8'($urandom), 1'($urandom));
    for (int i = 0; i < 1000; i++)
      run_op("rnd8", 1'b1, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
             8'($urandom), 1'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
